match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Parameters
REQ-001 WIN_TARGET, default 7, round wins needed to take the match (range 1..7).
REQ-002 HOLD_CYCLES, default 50_000_000, clk cycles of pause after each round (>=2).

Interface
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  synchronous, debounced single-cycle pulse requesting match start or restart.
REQ-006 wL  input  1  single-cycle pulse: left player won the current round.
REQ-007 wR  input  1  single-cycle pulse: right player won the current round.
REQ-008 play_en  output  1  high only while a round is live; gates player/computer press inputs.
REQ-009 field_clr  output  1  single-cycle pulse that re-centres the light field and clears round-win state.
REQ-010 scoreL  output  3  left player's round wins this match.
REQ-011 scoreR  output  3  right player's round wins this match.
REQ-012 match_over  output  1  high while the match is decided.
REQ-013 champL  output  1  high while match_over and left won.
REQ-014 champR  output  1  high while match_over and right won.

Function
REQ-015 FSM states SHALL be IDLE, PLAY, HOLD, DONE; all outputs SHALL be registered.
REQ-016 IDLE: play_en=0; on start SHALL pulse field_clr the next cycle and enter PLAY; wL/wR SHALL be ignored.
REQ-017 PLAY: play_en=1; wL alone SHALL increment scoreL, clear play_en and enter HOLD on the next edge.
REQ-018 PLAY: wR alone SHALL increment scoreR, clear play_en and enter HOLD on the next edge.
REQ-019 PLAY: wL and wR in the same cycle SHALL count as a tie: no score change, enter HOLD (round replayed).
REQ-020 HOLD: play_en=0; a down-counter loaded with HOLD_CYCLES-1 on entry SHALL decrement each cycle; wL/wR/start SHALL be ignored.
REQ-021 HOLD expiry: if scoreL or scoreR equals WIN_TARGET, SHALL enter DONE; otherwise SHALL pulse field_clr and enter PLAY on the same edge.
REQ-022 Total HOLD duration SHALL be exactly HOLD_CYCLES cycles from the first HOLD cycle to the first PLAY cycle.
REQ-023 DONE: match_over=1, play_en=0, the matching champ flag =1, scores held; wL/wR SHALL be ignored.
REQ-024 DONE: start SHALL clear both scores, clear match_over/champ flags, pulse field_clr and enter PLAY on the next edge.
REQ-025 start in PLAY SHALL abort the match: scores cleared, field_clr pulsed, remain in PLAY.
REQ-026 Scores SHALL saturate at WIN_TARGET and never wrap; champL and champR SHALL never both be 1.
REQ-027 field_clr SHALL never be high for two consecutive cycles.
REQ-028 Hold-counter width SHALL be $clog2(HOLD_CYCLES); no combinational path from inputs to outputs.

Reset
REQ-029 On reset=0, immediately: state=IDLE, play_en=0, field_clr=0, scoreL=scoreR=0, match_over=0, champL=champR=0, hold counter=0.
REQ-030 Reset asserted mid-HOLD or mid-PLAY SHALL discard the round in progress; after release the block SHALL wait in IDLE for start.

Verification (HOLD_CYCLES=4, WIN_TARGET=2)
REQ-031 Reset release, start pulse -> field_clr high 1 cycle, play_en=1 next cycle, scores 0/0.
REQ-032 PLAY, wL pulse -> scoreL=1, play_en=0 for exactly 4 cycles, field_clr pulse, play_en=1.
REQ-033 PLAY, wL and wR same cycle -> scores unchanged, HOLD 4 cycles, replay round.
REQ-034 Two wR wins -> scoreR=2, after HOLD: match_over=1, champR=1, champL=0; further wL ignored.
REQ-035 DONE, start -> scores 0/0, match_over=0, field_clr pulse, play_en=1.
REQ-036 reset=0 during HOLD cycle 2 -> all outputs zero immediately; wL after release ignored until start.

Source files
------------

// File: rtl/match_ctrl.sv
// match_ctrl: sequences a best-of match as a series of rounds.
//   IDLE -> (start) -> PLAY -> (round won or tied) -> HOLD -> PLAY ... -> DONE
//   After each round a fixed pause of HOLD_CYCLES cycles elapses. The block
//   then re-centres the field for the next round, or declares the match
//   decided once either score reaches WIN_TARGET.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      single-cycle start/restart request (already debounced)
//   wL / wR    single-cycle round-win pulses for the left / right player
//   play_en    high while a round is live
//   field_clr  single-cycle pulse that re-centres the light field
//   scoreL/R   round wins this match
//   match_over high while the match is decided
//   champL/R   winner flags, valid while match_over
//
// Every output comes directly from a flop, so no input reaches an output
// combinationally.
module match_ctrl #(
  parameter int unsigned WIN_TARGET  = 7,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wL,
  input  logic       wR,
  output logic       play_en,
  output logic       field_clr,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic       match_over,
  output logic       champL,
  output logic       champR
);

  localparam int unsigned SCORE_W = 3;
  localparam int unsigned CNT_W   = $clog2(HOLD_CYCLES);

  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [SCORE_W-1:0] score_l_q,    score_l_d;
  logic [SCORE_W-1:0] score_r_q,    score_r_d;
  logic               play_en_q,    play_en_d;
  logic               field_clr_q,  field_clr_d;
  logic               match_over_q, match_over_d;
  logic               champ_l_q,    champ_l_d;
  logic               champ_r_q,    champ_r_d;

  logic win_l_reached;
  logic win_r_reached;

  assign win_l_reached = (score_l_q == WIN);
  assign win_r_reached = (score_r_q == WIN);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    field_clr_d  = 1'b0;
    match_over_d = match_over_q;
    champ_l_d    = champ_l_q;
    champ_r_d    = champ_r_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = PLAY;
          field_clr_d = 1'b1;
        end
      end

      PLAY: begin
        if (start) begin
          // Abort: restart the match in place. The field was already
          // cleared if field_clr is high right now, so skip a second pulse.
          score_l_d   = '0;
          score_r_d   = '0;
          field_clr_d = ~field_clr_q;
        end else if (wL && wR) begin
          // Simultaneous wins are a tie: pause, then replay the round.
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end else if (wL) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
          if (score_l_q < WIN) begin
            score_l_d = score_l_q + SCORE_W'(1);
          end
        end else if (wR) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
          if (score_r_q < WIN) begin
            score_r_d = score_r_q + SCORE_W'(1);
          end
        end
      end

      HOLD: begin
        // The counter is loaded with HOLD_CYCLES-1 and the exit happens on
        // the cycle it reads zero, so the pause lasts exactly HOLD_CYCLES.
        if (cnt_q == '0) begin
          if (win_l_reached || win_r_reached) begin
            state_d      = DONE;
            match_over_d = 1'b1;
            champ_l_d    = win_l_reached;
            champ_r_d    = win_r_reached && !win_l_reached;
          end else begin
            state_d     = PLAY;
            field_clr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        if (start) begin
          state_d      = PLAY;
          score_l_d    = '0;
          score_r_d    = '0;
          match_over_d = 1'b0;
          champ_l_d    = 1'b0;
          champ_r_d    = 1'b0;
          field_clr_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    play_en_d = (state_d == PLAY);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      play_en_q    <= 1'b0;
      field_clr_q  <= 1'b0;
      match_over_q <= 1'b0;
      champ_l_q    <= 1'b0;
      champ_r_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      play_en_q    <= play_en_d;
      field_clr_q  <= field_clr_d;
      match_over_q <= match_over_d;
      champ_l_q    <= champ_l_d;
      champ_r_q    <= champ_r_d;
    end
  end

  assign play_en    = play_en_q;
  assign field_clr  = field_clr_q;
  assign scoreL     = score_l_q;
  assign scoreR     = score_r_q;
  assign match_over = match_over_q;
  assign champL     = champ_l_q;
  assign champR     = champ_r_q;

  // Invariants of the output protocol
  a_clr_single : assert property (@(posedge clk) disable iff (!reset)
    field_clr_q |=> !field_clr_q);

  a_champ_excl : assert property (@(posedge clk) disable iff (!reset)
    !(champ_l_q && champ_r_q));

  a_score_sat : assert property (@(posedge clk) disable iff (!reset)
    (score_l_q <= WIN) && (score_r_q <= WIN));

endmodule

// File: tb/tb_match_ctrl.sv
// Testbench for match_ctrl with WIN_TARGET=2, HOLD_CYCLES=4.
// A round-level model predicts the outputs, and a compare process checks
// them on every falling edge. Literal checks at key points pin the model.
module tb_match_ctrl;

  localparam int T = 2;
  localparam int H = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       wL;
  logic       wR;
  logic       play_en;
  logic       field_clr;
  logic [2:0] scoreL;
  logic [2:0] scoreR;
  logic       match_over;
  logic       champL;
  logic       champR;

  int n_vec = 0;
  int n_err = 0;

  // Model state, expressed as round-level facts
  bit m_idle;
  bit m_live;
  bit m_decided;
  int m_winner;   // 0 none, 1 left, 2 right
  int m_hold;     // remaining pause cycles
  int m_sl;
  int m_sr;
  bit m_clr;

  match_ctrl #(
    .WIN_TARGET (T),
    .HOLD_CYCLES(H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .wL        (wL),
    .wR        (wR),
    .play_en   (play_en),
    .field_clr (field_clr),
    .scoreL    (scoreL),
    .scoreR    (scoreR),
    .match_over(match_over),
    .champL    (champL),
    .champR    (champR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle    = 1'b1;
    m_live    = 1'b0;
    m_decided = 1'b0;
    m_winner  = 0;
    m_hold    = 0;
    m_sl      = 0;
    m_sr      = 0;
    m_clr     = 1'b0;
  endtask

  // One clock edge of the match rules
  task automatic model_edge(input logic s, input logic l, input logic r);
    bit clr_n;
    clr_n = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        if (m_sl == T || m_sr == T) begin
          m_decided = 1'b1;
          m_winner  = (m_sl == T) ? 1 : 2;
        end else begin
          m_live = 1'b1;
          clr_n  = 1'b1;
        end
      end
    end else if (m_live) begin
      if (s) begin
        m_sl  = 0;
        m_sr  = 0;
        clr_n = !m_clr;
      end else if (l || r) begin
        m_live = 1'b0;
        m_hold = H;
        if (l && !r && m_sl < T) m_sl++;
        if (r && !l && m_sr < T) m_sr++;
      end
    end else if (s && (m_idle || m_decided)) begin
      m_idle    = 1'b0;
      m_decided = 1'b0;
      m_winner  = 0;
      m_sl      = 0;
      m_sr      = 0;
      m_live    = 1'b1;
      clr_n     = 1'b1;
    end
    m_clr = clr_n;
  endtask

  // Drive one cycle of inputs; returns at falling edge + 1
  task automatic tick(input logic s, input logic l, input logic r);
    start = s;
    wL    = l;
    wR    = r;
    @(posedge clk);
    if (reset) model_edge(s, l, r);
    else       model_reset();
    @(negedge clk);
    #1;
    start = 1'b0;
    wL    = 1'b0;
    wR    = 1'b0;
  endtask

  // Run through a pause, counting cycles until play resumes or the match ends
  task automatic wait_hold(output int n);
    n = 0;
    while (!play_en && !match_over && n < 10) begin
      n++;
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    check("play_en",    32'(play_en),    32'(m_live && m_hold == 0));
    check("field_clr",  32'(field_clr),  32'(m_clr));
    check("scoreL",     32'(scoreL),     32'(m_sl));
    check("scoreR",     32'(scoreR),     32'(m_sr));
    check("match_over", 32'(match_over), 32'(m_decided));
    check("champL",     32'(champL),     32'(m_decided && m_winner == 1));
    check("champR",     32'(champR),     32'(m_decided && m_winner == 2));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    wL    = 1'b0;
    wR    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("lit_rst_play_en", 32'(play_en), 32'd0);
    check("lit_rst_scores",  32'({scoreL, scoreR}), 32'd0);
    reset = 1'b1;

    // IDLE ignores round wins
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("lit_idle_wl_score", 32'(scoreL), 32'd0);
    check("lit_idle_play_en",  32'(play_en), 32'd0);

    // Start: field cleared and play live together
    tick(1'b1, 1'b0, 1'b0);
    check("lit_start_clr",  32'(field_clr), 32'd1);
    check("lit_start_play", 32'(play_en),   32'd1);
    tick(1'b0, 1'b0, 1'b0);
    check("lit_clr_single", 32'(field_clr), 32'd0);

    // Left wins a round; the pause ignores every input
    tick(1'b0, 1'b1, 1'b0);
    check("lit_wl_score", 32'(scoreL),  32'd1);
    check("lit_wl_pause", 32'(play_en), 32'd0);
    n = 0;
    while (!play_en && n < 10) begin
      n++;
      if (n == 1) tick(1'b1, 1'b1, 1'b1);
      else        tick(1'b0, 1'b0, 1'b0);
    end
    check("lit_hold_len",    32'(n),         32'd4);
    check("lit_hold_clr",    32'(field_clr), 32'd1);
    check("lit_hold_scoreL", 32'(scoreL),    32'd1);

    // Tie: no score change, round replayed after the pause
    tick(1'b0, 1'b1, 1'b1);
    wait_hold(n);
    check("lit_tie_len",    32'(n),      32'd4);
    check("lit_tie_scoreL", 32'(scoreL), 32'd1);
    check("lit_tie_scoreR", 32'(scoreR), 32'd0);

    // Abort in PLAY on the field_clr cycle, then again one cycle later
    tick(1'b1, 1'b0, 1'b0);
    check("lit_abort_scoreL", 32'(scoreL),    32'd0);
    check("lit_abort_noclr",  32'(field_clr), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("lit_abort_clr",    32'(field_clr), 32'd1);
    check("lit_abort_play",   32'(play_en),   32'd1);
    tick(1'b0, 1'b0, 1'b0);

    // Right takes the match
    tick(1'b0, 1'b0, 1'b1);
    wait_hold(n);
    tick(1'b0, 1'b0, 1'b1);
    wait_hold(n);
    check("lit_done_len",    32'(n),          32'd4);
    check("lit_done_over",   32'(match_over), 32'd1);
    check("lit_done_champR", 32'(champR),     32'd1);
    check("lit_done_champL", 32'(champL),     32'd0);
    check("lit_done_scoreR", 32'(scoreR),     32'd2);
    tick(1'b0, 1'b1, 1'b0);
    check("lit_done_wl_ign", 32'(scoreL),     32'd0);
    tick(1'b0, 1'b0, 1'b0);

    // Restart from DONE
    tick(1'b1, 1'b0, 1'b0);
    check("lit_restart_scores", 32'({scoreL, scoreR}), 32'd0);
    check("lit_restart_over",   32'(match_over),       32'd0);
    check("lit_restart_clr",    32'(field_clr),        32'd1);
    check("lit_restart_play",   32'(play_en),          32'd1);

    // Left takes a match
    tick(1'b0, 1'b1, 1'b0);
    wait_hold(n);
    tick(1'b0, 1'b1, 1'b0);
    wait_hold(n);
    check("lit_left_champL", 32'(champL), 32'd1);
    check("lit_left_champR", 32'(champR), 32'd0);
    check("lit_left_scoreL", 32'(scoreL), 32'd2);

    // Reset in the second pause cycle discards the round
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    check("lit_async_play",   32'(play_en),          32'd0);
    check("lit_async_clr",    32'(field_clr),        32'd0);
    check("lit_async_scores", 32'({scoreL, scoreR}), 32'd0);
    check("lit_async_flags",  32'({match_over, champL, champR}), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    check("lit_post_rst_wl",   32'(scoreL),  32'd0);
    check("lit_post_rst_idle", 32'(play_en), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    check("lit_post_rst_start", 32'(play_en), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
